// File: rtl/sha_double_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sha_double_pipe
// Description : Fully unrolled Bitcoin double-SHA256 pipeline, one nonce per
//               clock in and one digest per clock out.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_double_pipe #(
    parameter int ROUNDS_FIRST  = 63,
    parameter int ROUNDS_SECOND = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         write_en,
    input  logic [255:0] digest_intial,
    input  logic [255:0] digest_in,
    input  logic [31:0]  merkle_in,
    input  logic [31:0]  time_in,
    input  logic [31:0]  target_in,
    input  logic [31:0]  nonce_in,
    output logic         valid_out,
    output logic [31:0]  time_out,
    output logic [31:0]  nonce_out,
    output logic [255:0] result_out
);

    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] c_iv =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on a..h packed with a in the top word.
    function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Slide the 16-word window by one, appending W[t+16]; window word 0 is in [511:480].
    function automatic logic [511:0] win_shift(input logic [511:0] win);
        return {win[479:0], small_s1(win[63:32]) + win[223:192] + small_s0(win[479:448]) + win[511:480]};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    logic [255:0] r_mid;
    logic [255:0] r_state0;
    logic [31:0]  r_merkle;
    logic [31:0]  r_target;
    logic [31:0]  r_time_cnt;
    logic [31:0]  r_nonce_cnt;
    logic [511:0] w_block1;

    // Work registers load only while held in reset; counters sweep while running.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (write_en) begin
                r_mid       <= digest_intial;
                r_state0    <= digest_in;
                r_merkle    <= merkle_in;
                r_target    <= target_in;
                r_time_cnt  <= time_in;
                r_nonce_cnt <= nonce_in;
            end
        end else begin
            r_nonce_cnt <= r_nonce_cnt + 32'd1;
            if (r_nonce_cnt == 32'hffff_ffff) begin
                r_time_cnt <= r_time_cnt + 32'd1;
            end
        end
    end

    assign w_block1 = {r_merkle, r_time_cnt, r_target, r_nonce_cnt, 32'h8000_0000, 320'd0, 32'h0000_0280};

    logic [255:0] r_s1_state [0:ROUNDS_FIRST];
    logic [511:0] r_s1_win   [0:ROUNDS_FIRST-1];
    logic [31:0]  r_s1_time  [0:ROUNDS_FIRST];
    logic [31:0]  r_s1_nonce [0:ROUNDS_FIRST];
    logic         r_s1_vld   [0:ROUNDS_FIRST];

    // Round 0 is precomputed in software, so the window starts at W1.
    always_ff @(posedge CLK) begin
        r_s1_state[0] <= r_state0;
        r_s1_win[0]   <= win_shift(w_block1);
        r_s1_time[0]  <= r_time_cnt;
        r_s1_nonce[0] <= r_nonce_cnt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_s1_vld[0] <= 1'b0;
        else      r_s1_vld[0] <= 1'b1;
    end

    for (genvar gi = 1; gi <= ROUNDS_FIRST; gi++) begin : g_first
        localparam int c_rnd = 64 - ROUNDS_FIRST + gi - 1;

        always_ff @(posedge CLK) begin
            r_s1_state[gi] <= sha_round(r_s1_state[gi-1], c_k[c_rnd], r_s1_win[gi-1][511:480]);
            r_s1_time[gi]  <= r_s1_time[gi-1];
            r_s1_nonce[gi] <= r_s1_nonce[gi-1];
        end

        if (gi < ROUNDS_FIRST) begin : g_win
            always_ff @(posedge CLK) begin
                r_s1_win[gi] <= win_shift(r_s1_win[gi-1]);
            end
        end

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) r_s1_vld[gi] <= 1'b0;
            else      r_s1_vld[gi] <= r_s1_vld[gi-1];
        end
    end

    logic [255:0] r_h1;
    logic [31:0]  r_h1_time;
    logic [31:0]  r_h1_nonce;
    logic         r_h1_vld;

    always_ff @(posedge CLK) begin
        r_h1       <= add8(r_s1_state[ROUNDS_FIRST], r_mid);
        r_h1_time  <= r_s1_time[ROUNDS_FIRST];
        r_h1_nonce <= r_s1_nonce[ROUNDS_FIRST];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_h1_vld <= 1'b0;
        else      r_h1_vld <= r_s1_vld[ROUNDS_FIRST];
    end

    logic [255:0] r_s2_state [0:ROUNDS_SECOND];
    logic [511:0] r_s2_win   [0:ROUNDS_SECOND-1];
    logic [31:0]  r_s2_time  [0:ROUNDS_SECOND];
    logic [31:0]  r_s2_nonce [0:ROUNDS_SECOND];
    logic         r_s2_vld   [0:ROUNDS_SECOND];

    // Second hash is seeded with the IV and the padded 32-byte first digest.
    always_ff @(posedge CLK) begin
        r_s2_state[0] <= c_iv;
        r_s2_win[0]   <= {r_h1, 32'h8000_0000, 192'd0, 32'h0000_0100};
        r_s2_time[0]  <= r_h1_time;
        r_s2_nonce[0] <= r_h1_nonce;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_s2_vld[0] <= 1'b0;
        else      r_s2_vld[0] <= r_h1_vld;
    end

    for (genvar gj = 1; gj <= ROUNDS_SECOND; gj++) begin : g_second
        localparam int c_rnd = 64 - ROUNDS_SECOND + gj - 1;

        always_ff @(posedge CLK) begin
            r_s2_state[gj] <= sha_round(r_s2_state[gj-1], c_k[c_rnd], r_s2_win[gj-1][511:480]);
            r_s2_time[gj]  <= r_s2_time[gj-1];
            r_s2_nonce[gj] <= r_s2_nonce[gj-1];
        end

        if (gj < ROUNDS_SECOND) begin : g_win
            always_ff @(posedge CLK) begin
                r_s2_win[gj] <= win_shift(r_s2_win[gj-1]);
            end
        end

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) r_s2_vld[gj] <= 1'b0;
            else      r_s2_vld[gj] <= r_s2_vld[gj-1];
        end
    end

    logic [255:0] r_fin;
    logic [31:0]  r_fin_time;
    logic [31:0]  r_fin_nonce;
    logic         r_fin_vld;

    // Final IV addition is registered ahead of the output flops.
    always_ff @(posedge CLK) begin
        r_fin       <= add8(r_s2_state[ROUNDS_SECOND], c_iv);
        r_fin_time  <= r_s2_time[ROUNDS_SECOND];
        r_fin_nonce <= r_s2_nonce[ROUNDS_SECOND];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_fin_vld <= 1'b0;
        else      r_fin_vld <= r_s2_vld[ROUNDS_SECOND];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_out  <= 1'b0;
            result_out <= 256'd0;
            time_out   <= 32'd0;
            nonce_out  <= 32'd0;
        end else begin
            valid_out  <= r_fin_vld;
            result_out <= r_fin;
            time_out   <= r_fin_time;
            nonce_out  <= r_fin_nonce;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_double_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_double_pipe
// Description : Self-checking bench for sha_double_pipe against a loop-based
//               double-SHA256 model plus hand-computed golden values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_double_pipe;

    logic         CLK;
    logic         RST;
    logic         write_en;
    logic [255:0] digest_intial;
    logic [255:0] digest_in;
    logic [31:0]  merkle_in, time_in, target_in, nonce_in;
    logic         valid_out;
    logic [31:0]  time_out, nonce_out;
    logic [255:0] result_out;

    sha_double_pipe #(.ROUNDS_FIRST(63), .ROUNDS_SECOND(64)) dut (
        .CLK(CLK), .RST(RST), .write_en(write_en),
        .digest_intial(digest_intial), .digest_in(digest_in),
        .merkle_in(merkle_in), .time_in(time_in), .target_in(target_in), .nonce_in(nonce_in),
        .valid_out(valid_out), .time_out(time_out), .nonce_out(nonce_out), .result_out(result_out)
    );

    localparam logic [255:0] G_MID  = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
    localparam logic [255:0] G_ST   = 256'hF7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776;
    localparam logic [255:0] G_HASH = 256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000;
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_checks = 0;
    int n_pass   = 0;
    int run_cyc  = 0;
    bit chk_en   = 1'b0;

    // Work values the model hashes with (the last ones captured with write_en=1).
    logic [255:0] m_mid, m_st;
    logic [31:0]  m_merkle, m_time, m_target, m_nonce;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle c = number of rising edges seen with RST high since the last reset.
    always @(posedge CLK) begin
        if (!RST) run_cyc = 0;
        else      run_cyc = run_cyc + 1;
    end

    task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain SHA-256 rounds first..63 over a full 64-entry schedule; no final add.
    function automatic logic [255:0] rounds(input logic [255:0] st, input logic [511:0] blk, input int first);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
        for (int t = first; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [255:0] double_sha(input logic [31:0] tm, input logic [31:0] nc);
        logic [255:0] h1;
        h1 = add8(rounds(m_st, {m_merkle, tm, m_target, nc, 32'h80000000, 320'd0, 32'h280}, 1), m_mid);
        return add8(rounds(IV, {h1, 32'h80000000, 192'd0, 32'h100}, 0), IV);
    endfunction

    // Cycle-by-cycle compare against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            if (!RST) begin
                check("reset_outputs", {valid_out, time_out, nonce_out, result_out}, 320'd0);
            end else if (run_cyc < 132) begin
                check("valid_before_latency", {319'd0, valid_out}, 320'd0);
            end else begin
                logic [32:0] sum;
                logic [31:0] et, en;
                sum = {1'b0, m_nonce} + 33'(run_cyc - 132);
                en  = sum[31:0];
                et  = m_time + {31'd0, sum[32]};
                check("stream_valid", {319'd0, valid_out}, 320'd1);
                check("stream_tags", {256'd0, time_out, nonce_out}, {256'd0, et, en});
                check("stream_hash", {64'd0, result_out}, {64'd0, double_sha(et, en)});
            end
        end
    end

    task automatic load(input logic [31:0] tm, input logic [31:0] nc, input int edges);
        @(posedge CLK); #1;
        RST = 1'b0;
        digest_intial = G_MID; digest_in = G_ST;
        merkle_in = 32'h252DB801; target_in = 32'h6461011A;
        time_in = tm; nonce_in = nc;
        write_en = 1'b1;
        repeat (edges) @(posedge CLK);
        #1;
        write_en = 1'b0;
        m_mid = G_MID; m_st = G_ST; m_merkle = 32'h252DB801; m_target = 32'h6461011A;
        m_time = tm; m_nonce = nc;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!(RST && run_cyc == n) && guard < 1000);
        if (guard >= 1000) check("wait_cycle_timeout", 320'(run_cyc), 320'(n));
    endtask

    task automatic check_tag(input string name, input logic [31:0] tm, input logic [31:0] nc);
        check(name, {255'd0, valid_out, time_out, nonce_out}, {255'd0, 1'b1, tm, nc});
    endtask

    initial begin
        RST = 1'b1; write_en = 1'b0;
        digest_intial = '0; digest_in = '0;
        merkle_in = '0; time_in = '0; target_in = '0; nonce_in = '0;
        #1 RST = 1'b0;
        chk_en = 1'b1;

        // Load and count across a nonce wrap.
        load(32'hAAAAAAA1, 32'hFFFFFFF0, 2);
        RST = 1'b1;
        wait_cyc(132); check_tag("first_tag", 32'hAAAAAAA1, 32'hFFFFFFF0);
        wait_cyc(148); check_tag("wrap_tag", 32'hAAAAAAA2, 32'h00000000);
        wait_cyc(149); check_tag("after_wrap_tag", 32'hAAAAAAA2, 32'h00000001);
        wait_cyc(150);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1 check("async_clear", {valid_out, time_out, nonce_out, result_out}, 320'd0);

        // Golden header, with changing inputs held off by write_en=0 during reset.
        load(32'h130DAE51, 32'h3AEB9BB0, 1);
        digest_intial = ~G_MID; digest_in = ~G_ST;
        merkle_in = 32'h1; time_in = 32'h2; target_in = 32'h3; nonce_in = 32'h4;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        wait_cyc(131); check("valid_at_131", {319'd0, valid_out}, 320'd0);
        wait_cyc(132); check_tag("golden_first_tag", 32'h130DAE51, 32'h3AEB9BB0);
        wait_cyc(140);
        check_tag("golden_tag", 32'h130DAE51, 32'h3AEB9BB8);
        check("golden_hash", {64'd0, result_out}, {64'd0, G_HASH});
        wait_cyc(145);

        // Reset mid-run, reload, and look for stale results.
        load(32'h130DAE51, 32'h00000100, 1);
        RST = 1'b1;
        wait_cyc(50);
        #1 RST = 1'b0;
        load(32'h130DAE51, 32'h55555555, 1);
        RST = 1'b1;
        wait_cyc(132); check_tag("restart_first_tag", 32'h130DAE51, 32'h55555555);
        wait_cyc(134);

        // Nonce wrap tagging on the output side.
        load(32'h130DAE51, 32'hFFFFFFFE, 1);
        RST = 1'b1;
        wait_cyc(132); check_tag("tag_fffffffe", 32'h130DAE51, 32'hFFFFFFFE);
        wait_cyc(133); check_tag("tag_ffffffff", 32'h130DAE51, 32'hFFFFFFFF);
        wait_cyc(134); check_tag("tag_00000000", 32'h130DAE52, 32'h00000000);
        wait_cyc(135);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
